// File: rtl/request_unit_ctl.sv
// Memory request sequencer for the CPU core: launches data requests after an
// instruction fetch, tracks their wait time, and can stall fetch on a shared port.
module request_unit_ctl #(
  parameter int STALL_IFETCH = 0,
  parameter int TMO_W        = 8,
  parameter int TMO_LIMIT    = 200
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic             halt,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             busy,
  output logic             timeout,
  output logic [TMO_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    DREQ,
    HALTED
  } state_t;

  localparam logic [TMO_W-1:0] WAIT_MAX = '1;
  localparam logic [TMO_W-1:0] LIMIT_M1 = TMO_W'(TMO_LIMIT - 1);

  state_t           r_state;
  logic             r_dmemREN;
  logic             r_dmemWEN;
  logic             r_timeout;
  logic [TMO_W-1:0] r_waitCnt;

  state_t           w_nextState;
  logic             w_nextREN;
  logic             w_nextWEN;
  logic             w_nextTimeout;
  logic [TMO_W-1:0] w_nextWaitCnt;
  logic             w_pcEn;
  logic             w_imemREN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_dmemREN <= 1'b0;
      r_dmemWEN <= 1'b0;
      r_timeout <= 1'b0;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_dmemREN <= w_nextREN;
      r_dmemWEN <= w_nextWEN;
      r_timeout <= w_nextTimeout;
      r_waitCnt <= w_nextWaitCnt;
    end
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextREN     = r_dmemREN;
    w_nextWEN     = r_dmemWEN;
    w_nextTimeout = r_timeout;
    w_nextWaitCnt = r_waitCnt;
    w_pcEn        = 1'b0;
    w_imemREN     = 1'b1;

    case (r_state)
      IDLE: begin
        w_imemREN = 1'b1;
        if (ihit) begin
          if (dREN || dWEN) begin
            // A store wins when the decoder flags both load and store.
            w_nextState   = DREQ;
            w_nextWEN     = dWEN;
            w_nextREN     = dREN & ~dWEN;
            w_nextWaitCnt = '0;
          end else if (halt) begin
            w_nextState = HALTED;
          end else begin
            w_pcEn = 1'b1;
          end
        end
      end

      DREQ: begin
        w_imemREN = (STALL_IFETCH == 0);
        if (dhit) begin
          w_pcEn      = 1'b1;
          w_nextState = IDLE;
          w_nextREN   = 1'b0;
          w_nextWEN   = 1'b0;
        end else begin
          // The request stays up after a timeout; the flag is only a sticky report.
          if (r_waitCnt != WAIT_MAX) begin
            w_nextWaitCnt = r_waitCnt + 1'b1;
          end
          if (r_waitCnt == LIMIT_M1) begin
            w_nextTimeout = 1'b1;
          end
        end
      end

      HALTED: begin
        w_imemREN = 1'b0;
        w_nextREN = 1'b0;
        w_nextWEN = 1'b0;
      end

      default: begin
        w_nextState = IDLE;
        w_nextREN   = 1'b0;
        w_nextWEN   = 1'b0;
      end
    endcase
  end

  // pc_en is combinational from ihit/dhit, so it must be masked while reset is held.
  assign pc_en    = w_pcEn & nRST;
  assign imemREN  = w_imemREN;
  assign dmemREN  = r_dmemREN;
  assign dmemWEN  = r_dmemWEN;
  assign busy     = (r_state == DREQ);
  assign timeout  = r_timeout;
  assign wait_cnt = r_waitCnt;

endmodule

// File: tb/tb_request_unit_ctl.sv
// Bench for request_unit_ctl: two instances (shared port with small counter, split
// port with wide counter) driven identically and compared against a behavioural model.
module tb_request_unit_ctl;

  localparam int A_W = 8;
  localparam int A_LIMIT = 6;
  localparam int B_W = 3;
  localparam int B_LIMIT = 4;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit = 1'b0;
  logic dhit = 1'b0;
  logic dREN = 1'b0;
  logic dWEN = 1'b0;
  logic halt = 1'b0;

  logic imemA, renA, wenA, pcA, busyA, toA;
  logic [A_W-1:0] waitA;
  logic imemB, renB, wenB, pcB, busyB, toB;
  logic [B_W-1:0] waitB;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: request outstanding, halted, request kind, raw wait count.
  bit mBusy, mHalted, mRd, mWr, mToA, mToB;
  int mWaited;

  request_unit_ctl #(.STALL_IFETCH(0), .TMO_W(A_W), .TMO_LIMIT(A_LIMIT)) dutA (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .halt(halt), .imemREN(imemA), .dmemREN(renA), .dmemWEN(wenA), .pc_en(pcA),
    .busy(busyA), .timeout(toA), .wait_cnt(waitA)
  );

  request_unit_ctl #(.STALL_IFETCH(1), .TMO_W(B_W), .TMO_LIMIT(B_LIMIT)) dutB (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .halt(halt), .imemREN(imemB), .dmemREN(renB), .dmemWEN(wenB), .pc_en(pcB),
    .busy(busyB), .timeout(toB), .wait_cnt(waitB)
  );

  always #5 CLK = ~CLK;

  function automatic int satMin(input int v, input int w);
    int maxVal;
    maxVal = (1 << w) - 1;
    return (v > maxVal) ? maxVal : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAll(input bit expPc);
    checkOutput("busyA", 32'(busyA), 32'(mBusy));
    checkOutput("busyB", 32'(busyB), 32'(mBusy));
    checkOutput("dmemRENA", 32'(renA), 32'(mRd));
    checkOutput("dmemRENB", 32'(renB), 32'(mRd));
    checkOutput("dmemWENA", 32'(wenA), 32'(mWr));
    checkOutput("dmemWENB", 32'(wenB), 32'(mWr));
    checkOutput("pcEnA", 32'(pcA), 32'(expPc));
    checkOutput("pcEnB", 32'(pcB), 32'(expPc));
    checkOutput("imemRENA", 32'(imemA), 32'(!mHalted));
    checkOutput("imemRENB", 32'(imemB), 32'(!mHalted && !mBusy));
    checkOutput("timeoutA", 32'(toA), 32'(mToA));
    checkOutput("timeoutB", 32'(toB), 32'(mToB));
    checkOutput("waitCntA", 32'(waitA), satMin(mWaited, A_W));
    checkOutput("waitCntB", 32'(waitB), satMin(mWaited, B_W));
  endtask

  task automatic modelReset();
    mBusy = 0; mHalted = 0; mRd = 0; mWr = 0; mToA = 0; mToB = 0; mWaited = 0;
  endtask

  task automatic modelStep(input bit iH, input bit dH, input bit rd, input bit wr,
                           input bit hl);
    if (mHalted) begin
      mHalted = 1;
    end else if (mBusy) begin
      if (dH) begin
        mBusy = 0; mRd = 0; mWr = 0;
      end else begin
        mWaited++;
        if (mWaited == A_LIMIT) mToA = 1;
        if (mWaited == B_LIMIT) mToB = 1;
      end
    end else if (iH) begin
      if (rd || wr) begin
        mBusy = 1; mWr = wr; mRd = rd && !wr; mWaited = 0;
      end else if (hl) begin
        mHalted = 1;
      end
    end
  endtask

  task automatic applyStimulus(input bit iH, input bit dH, input bit rd, input bit wr,
                               input bit hl);
    bit expPc;
    @(negedge CLK);
    ihit = iH; dhit = dH; dREN = rd; dWEN = wr; halt = hl;
    #2;
    if (mHalted) expPc = 0;
    else if (mBusy) expPc = dH;
    else expPc = iH && !rd && !wr && !hl;
    checkAll(expPc);
    @(posedge CLK);
    modelStep(iH, dH, rd, wr, hl);
  endtask

  task automatic doReset();
    @(negedge CLK);
    nRST = 0; ihit = 1; dhit = 1; dREN = 0; dWEN = 0; halt = 0;
    modelReset();
    #2;
    checkAll(1'b0);
    @(negedge CLK);
    ihit = 0; dhit = 0;
    @(negedge CLK);
    nRST = 1;
  endtask

  // Reset dropped between clock edges must clear the request without waiting for CLK.
  task automatic asyncResetCheck();
    @(negedge CLK);
    ihit = 1; dhit = 0; dREN = 0; dWEN = 0; halt = 0;
    #3;
    nRST = 0;
    #1;
    modelReset();
    checkAll(1'b0);
    @(negedge CLK);
    ihit = 0;
    nRST = 1;
  endtask

  initial begin
    bit iH, dH, rd, wr, hl;
    int dhitDen;

    modelReset();
    doReset();

    repeat (3) applyStimulus(1, 0, 0, 0, 0);

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    applyStimulus(1, 0, 1, 0, 0);
    repeat (10) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    repeat (3) applyStimulus(1, 1, 1, 1, 0);

    doReset();
    applyStimulus(1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    asyncResetCheck();
    applyStimulus(1, 0, 0, 0, 0);

    for (int ep = 0; ep < 25; ep++) begin
      doReset();
      dhitDen = $urandom_range(1, 10);
      for (int c = 0; c < 40; c++) begin
        iH = ($urandom_range(0, 3) != 0);
        dH = ($urandom_range(1, dhitDen) == 1);
        rd = ($urandom_range(0, 2) == 0);
        wr = ($urandom_range(0, 3) == 0);
        hl = ($urandom_range(0, 24) == 0);
        applyStimulus(iH, dH, rd, wr, hl);
        if (mBusy && ($urandom_range(0, 30) == 0)) asyncResetCheck();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
